// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_param sequential ALU.
//   - op_code values (OP_ADD, OP_SUB, OP_MUL, OP_DIV)
//   - one-hot FSM state encoding
//   - Radix-4 Booth digit decode helper
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [8:0] {
        S_IDLE     = 9'b000000001,
        S_LOAD_Y   = 9'b000000010,
        S_ADDSUB   = 9'b000000100,
        S_MUL_IT   = 9'b000001000,
        S_DIV_PREP = 9'b000010000,
        S_DIV_IT   = 9'b000100000,
        S_DIV_FIX  = 9'b001000000,
        S_OUT_HI   = 9'b010000000,
        S_OUT_LO   = 9'b100000000
    } state_t;

    // Booth digit: zero -> add nothing, dbl -> use 2X, neg -> subtract.
    typedef struct packed {
        logic zero;
        logic neg;
        logic dbl;
    } booth_t;

    // bits = {Q[1], Q[0], Q[-1]}
    function automatic booth_t booth_decode(input logic [2:0] bits);
        booth_t d;
        d.zero = (bits == 3'b000) || (bits == 3'b111);
        d.neg  = bits[2];
        d.dbl  = (bits == 3'b011) || (bits == 3'b100);
        return d;
    endfunction

endpackage

// File: rtl/alu_param_if.sv
// alu_param_if: operand/result bus of the alu_param ALU.
//   master drives BEGIN, op_code, inbus; slave (the ALU) drives
//   outbus, out_valid, END, busy, ovf, dz.
interface alu_param_if #(parameter int WIDTH = 8);

    logic             BEGIN;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] inbus;
    logic [WIDTH-1:0] outbus;
    logic             out_valid;
    logic             END;
    logic             busy;
    logic             ovf;
    logic             dz;

    modport master (
        output BEGIN, op_code, inbus,
        input  outbus, out_valid, END, busy, ovf, dz
    );

    modport slave (
        input  BEGIN, op_code, inbus,
        output outbus, out_valid, END, busy, ovf, dz
    );

endinterface

// File: rtl/adder_rca.sv
// adder_rca: N-bit ripple-carry adder, sum = a + b + cin.
//   a, b : N-bit addends
//   cin  : carry in (1 with an inverted b gives a - b)
//   sum  : N-bit result, carry out discarded
module adder_rca #(
    parameter int N = 10
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

endmodule

// File: rtl/alu_param.sv
// alu_param: sequential WIDTH-bit signed ALU (add, sub, Radix-4 Booth
// multiply, restoring divide) with a single shared adder.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : alu_param_if slave (BEGIN/op_code/inbus in,
//           outbus/out_valid/END/busy/ovf/dz out, all registered)
module alu_param
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    alu_param_if.slave  bus
);

    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, next_state;
    logic [1:0]       op;
    logic [WIDTH-1:0] x, y, q, dvs;
    logic [AW-1:0]    acc;
    logic             qm1;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r;

    logic [AW-1:0]    add_a, add_b, sum;
    logic             add_cin;

    logic [WIDTH-1:0] out_word, out_word_nxt;
    logic             out_vld, out_vld_nxt, out_end, out_end_nxt;
    logic             busy_q, ovf_q, dz_q;

    adder_rca #(.N(AW)) u_add (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (sum)
    );

    // ---- derived datapath terms ----
    booth_t        bd;
    logic [AW-1:0] mcand;
    logic [AW-1:0] a_next;
    logic [WIDTH-1:0] q_next, div_shift;
    logic          is_sub, y_sign_eff, add_ovf, div_ok, last, y_zero, div_ovf;

    assign bd         = booth_decode({q[1], q[0], qm1});
    assign mcand      = bd.dbl ? {x[WIDTH-1], x, 1'b0} : {{2{x[WIDTH-1]}}, x};
    // {A,Q,Q[-1]} >>> 2 after this cycle's accumulate
    assign a_next     = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign q_next     = {sum[1:0], q[WIDTH-1:2]};
    // remainder < divisor <= 2^(WIDTH-1), so its top bit is always 0
    assign div_shift  = {acc[WIDTH-2:0], q[WIDTH-1]};
    assign div_ok     = ~sum[AW-1];
    assign is_sub     = (op == OP_SUB);
    assign y_sign_eff = is_sub ? ~y[WIDTH-1] : y[WIDTH-1];
    assign add_ovf    = (x[WIDTH-1] == y_sign_eff) && (sum[WIDTH-1] != x[WIDTH-1]);
    assign last       = (cnt == CW'(1));
    assign y_zero     = (y == '0);
    assign div_ovf    = (x == {1'b1, {(WIDTH-1){1'b0}}}) && (y == '1);

    // ---- shared adder operand mux ----
    // Negations (|X|, |Y|, sign fix-ups) are 0 + ~v + 1 through the same adder;
    // quotient fix-up happens in OUT_HI where the adder is otherwise idle.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        unique case (state)
            S_LOAD_Y: begin
                add_b   = ~{{2{x[WIDTH-1]}}, x};
                add_cin = 1'b1;
            end
            S_ADDSUB: begin
                add_a   = {{2{x[WIDTH-1]}}, x};
                add_b   = is_sub ? ~{{2{y[WIDTH-1]}}, y} : {{2{y[WIDTH-1]}}, y};
                add_cin = is_sub;
            end
            S_MUL_IT: begin
                add_a = acc;
                if (!bd.zero) begin
                    add_b   = bd.neg ? ~mcand : mcand;
                    add_cin = bd.neg;
                end
            end
            S_DIV_PREP: begin
                add_b   = ~{{2{y[WIDTH-1]}}, y};
                add_cin = 1'b1;
            end
            S_DIV_IT: begin
                add_a   = {2'b00, div_shift};
                add_b   = ~{2'b00, dvs};
                add_cin = 1'b1;
            end
            S_DIV_FIX: begin
                add_b   = ~{2'b00, acc[WIDTH-1:0]};
                add_cin = 1'b1;
            end
            S_OUT_HI: begin
                add_b   = ~{2'b00, q};
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // ---- FSM next state and next-cycle output words ----
    always_comb begin
        next_state   = state;
        out_word_nxt = '0;
        out_vld_nxt  = 1'b0;
        out_end_nxt  = 1'b0;
        unique case (state)
            S_IDLE:
                if (bus.BEGIN) next_state = S_LOAD_Y;
            S_LOAD_Y:
                case (op)
                    OP_MUL:  next_state = S_MUL_IT;
                    OP_DIV:  next_state = S_DIV_PREP;
                    default: next_state = S_ADDSUB;
                endcase
            S_ADDSUB: begin
                next_state   = S_OUT_LO;
                out_word_nxt = sum[WIDTH-1:0];
                out_vld_nxt  = 1'b1;
                out_end_nxt  = 1'b1;
            end
            S_MUL_IT:
                if (last) begin
                    next_state   = S_OUT_HI;
                    out_word_nxt = a_next[WIDTH-1:0];
                    out_vld_nxt  = 1'b1;
                end
            S_DIV_PREP:
                if (y_zero) begin
                    next_state   = S_OUT_HI;
                    out_word_nxt = x;
                    out_vld_nxt  = 1'b1;
                end else if (div_ovf) begin
                    next_state   = S_OUT_HI;
                    out_vld_nxt  = 1'b1;
                end else begin
                    next_state   = S_DIV_IT;
                end
            S_DIV_IT:
                if (last) next_state = S_DIV_FIX;
            S_DIV_FIX: begin
                next_state   = S_OUT_HI;
                out_word_nxt = neg_r ? sum[WIDTH-1:0] : acc[WIDTH-1:0];
                out_vld_nxt  = 1'b1;
            end
            S_OUT_HI: begin
                next_state   = S_OUT_LO;
                out_word_nxt = (op == OP_DIV && neg_q) ? sum[WIDTH-1:0] : q;
                out_vld_nxt  = 1'b1;
                out_end_nxt  = 1'b1;
            end
            S_OUT_LO:
                next_state = S_IDLE;
            default:
                next_state = S_IDLE;
        endcase
    end

    // ---- datapath and registered outputs ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op       <= '0;
            x        <= '0;
            y        <= '0;
            q        <= '0;
            dvs      <= '0;
            acc      <= '0;
            qm1      <= 1'b0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            out_word <= '0;
            out_vld  <= 1'b0;
            out_end  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            out_word <= out_word_nxt;
            out_vld  <= out_vld_nxt;
            out_end  <= out_end_nxt;
            busy_q   <= (next_state != S_IDLE);
            unique case (state)
                S_IDLE:
                    if (bus.BEGIN) begin
                        op    <= bus.op_code;
                        x     <= bus.inbus;
                        ovf_q <= 1'b0;
                        dz_q  <= 1'b0;
                    end
                S_LOAD_Y: begin
                    y   <= bus.inbus;
                    acc <= '0;
                    qm1 <= 1'b0;
                    if (op == OP_MUL) begin
                        q   <= bus.inbus;
                        cnt <= CW'(WIDTH / 2);
                    end else begin
                        // |X| staged as the dividend
                        q <= x[WIDTH-1] ? sum[WIDTH-1:0] : x;
                    end
                end
                S_ADDSUB:
                    ovf_q <= add_ovf;
                S_MUL_IT: begin
                    acc <= a_next;
                    q   <= q_next;
                    qm1 <= q[1];
                    cnt <= cnt - CW'(1);
                end
                S_DIV_PREP: begin
                    dvs   <= y[WIDTH-1] ? sum[WIDTH-1:0] : y;
                    acc   <= '0;
                    cnt   <= CW'(WIDTH);
                    neg_q <= x[WIDTH-1] ^ y[WIDTH-1];
                    neg_r <= x[WIDTH-1];
                    if (y_zero) begin
                        dz_q  <= 1'b1;
                        q     <= '1;
                        neg_q <= 1'b0;
                    end else if (div_ovf) begin
                        ovf_q <= 1'b1;
                        q     <= x;
                        neg_q <= 1'b0;
                    end
                end
                S_DIV_IT: begin
                    acc <= div_ok ? sum : {2'b00, div_shift};
                    q   <= {q[WIDTH-2:0], div_ok};
                    cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.outbus    = out_word;
    assign bus.out_valid = out_vld;
    assign bus.END       = out_end;
    assign bus.busy      = busy_q;
    assign bus.ovf       = ovf_q;
    assign bus.dz        = dz_q;

endmodule
